// File: rtl/obstacle_field.sv
// obstacle_field: N_OBST asteroid slots with LFSR spawning, bounce/exit motion, registered
// draw flag and frame-latched ship collision. Define OBST_WRAP_EN for vertical wrap-around.
`default_nettype none

module obstacle_field #(
    parameter int          N_OBST       = 4,
    parameter int          SCREEN_CORDW = 16,
    parameter int          H_RES        = 640,
    parameter int          V_RES        = 480,
    parameter int          OBST_SIZE    = 40,
    parameter int          SPAWN_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    frame,
    input  logic [SCREEN_CORDW-1:0] screen_x,
    input  logic [SCREEN_CORDW-1:0] screen_y,
    input  logic                    ship_drawing,
    output logic                    obst_drawing,
    output logic [N_OBST-1:0]       active_mask,
    output logic                    collision,
    output logic [N_OBST-1:0]       collision_mask,
    output logic [7:0]              hit_count
);

    localparam int CW = SCREEN_CORDW;
    localparam int TW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam logic [CW:0]   X_MAX  = (CW+1)'(H_RES - OBST_SIZE);
    localparam logic [CW:0]   Y_LIM  = (CW+1)'(V_RES);
    localparam logic [CW:0]   SIZE   = (CW+1)'(OBST_SIZE);
    localparam logic [TW-1:0] T_LAST = TW'(SPAWN_FRAMES - 1);

    logic [15:0]       lfsr_r;
    logic [CW-1:0]     x_r  [N_OBST];
    logic [CW-1:0]     y_r  [N_OBST];
    logic signed [1:0] dx_r [N_OBST];
    logic [2:0]        dy_r [N_OBST];
    logic [N_OBST-1:0] hit_acc_r;
    logic [N_OBST-1:0] slot_hit_r;
    logic [TW-1:0]     timer_r;

    logic [N_OBST-1:0] cover_s;
    logic [N_OBST-1:0] spawn_sel_s;
    logic              spawn_due_s;
    logic signed [1:0] spawn_dx_s;
    logic [N_OBST-1:0] act_nx_s;
    logic [CW-1:0]     x_nx_s  [N_OBST];
    logic [CW-1:0]     y_nx_s  [N_OBST];
    logic signed [1:0] dx_nx_s [N_OBST];
    logic [2:0]        dy_nx_s [N_OBST];
    logic [8:0]        hit_sum_s;

    function automatic logic [3:0] popcount(input logic [N_OBST-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < N_OBST; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    assign collision = |collision_mask;
    assign hit_sum_s = {1'b0, hit_count} + {5'd0, popcount(hit_acc_r)};

    // Coverage of the current beam position by each active slot.
    always_comb begin
        cover_s = '0;
        for (int i = 0; i < N_OBST; i++) begin
            cover_s[i] = active_mask[i]
                && ({1'b0, screen_x} >= {1'b0, x_r[i]})
                && ({1'b0, screen_x} < ({1'b0, x_r[i]} + SIZE))
                && ({1'b0, screen_y} >= {1'b0, y_r[i]})
                && ({1'b0, screen_y} < ({1'b0, y_r[i]} + SIZE));
        end
    end

    // Frame-boundary next state: retire on hit, otherwise move, otherwise maybe spawn.
    always_comb begin
        logic              found;
        logic [CW:0]       y_sum;
        logic signed [CW+1:0] x_sum;
        found       = 1'b0;
        y_sum       = '0;
        x_sum       = '0;
        spawn_sel_s = '0;
        spawn_due_s = (timer_r == T_LAST);
        for (int i = 0; i < N_OBST; i++) begin
            if (!active_mask[i] && !found) begin
                spawn_sel_s[i] = 1'b1;
                found          = 1'b1;
            end else begin
                spawn_sel_s[i] = 1'b0;
            end
        end
        case (lfsr_r[13:12])
            2'b00:   spawn_dx_s = -2'sd1;
            2'b11:   spawn_dx_s = 2'sd1;
            default: spawn_dx_s = 2'sd0;
        endcase
        for (int i = 0; i < N_OBST; i++) begin
            act_nx_s[i] = active_mask[i];
            x_nx_s[i]   = x_r[i];
            y_nx_s[i]   = y_r[i];
            dx_nx_s[i]  = dx_r[i];
            dy_nx_s[i]  = dy_r[i];
            y_sum = {1'b0, y_r[i]} + {{(CW-2){1'b0}}, dy_r[i]};
            x_sum = $signed({2'b00, x_r[i]}) + $signed({{CW{dx_r[i][1]}}, dx_r[i]});
            if (active_mask[i] && hit_acc_r[i]) begin
                act_nx_s[i] = 1'b0;
            end else if (active_mask[i]) begin
                if (y_sum >= Y_LIM) begin
`ifdef OBST_WRAP_EN
                    y_nx_s[i] = '0;
`else
                    act_nx_s[i] = 1'b0;
                    y_nx_s[i]   = y_sum[CW-1:0];
`endif
                end else begin
                    y_nx_s[i] = y_sum[CW-1:0];
                end
                // Bounce holds x in place for one frame and reverses direction.
                if (x_sum[CW+1] || (x_sum > $signed({1'b0, X_MAX}))) begin
                    dx_nx_s[i] = -dx_r[i];
                end else begin
                    x_nx_s[i] = x_sum[CW-1:0];
                end
            end else if (spawn_due_s && spawn_sel_s[i]) begin
                act_nx_s[i] = 1'b1;
                x_nx_s[i]   = {{(CW-9){1'b0}}, lfsr_r[8:0]};
                y_nx_s[i]   = '0;
                dy_nx_s[i]  = 3'd1 + {1'b0, lfsr_r[11:10]};
                dx_nx_s[i]  = spawn_dx_s;
            end else begin
                act_nx_s[i] = 1'b0;
            end
        end
    end

    // All field state: LFSR, draw/hit pipeline, collision latch and per-slot registers.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            lfsr_r         <= LFSR_SEED;
            obst_drawing   <= 1'b0;
            slot_hit_r     <= '0;
            hit_acc_r      <= '0;
            collision_mask <= '0;
            active_mask    <= '0;
            hit_count      <= 8'd0;
            timer_r        <= '0;
            for (int i = 0; i < N_OBST; i++) begin
                x_r[i]  <= '0;
                y_r[i]  <= '0;
                dx_r[i] <= 2'sd0;
                dy_r[i] <= 3'd0;
            end
        end else begin
            lfsr_r       <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
            slot_hit_r   <= en ? cover_s : '0;
            obst_drawing <= en && (|cover_s);
            if (frame) begin
                hit_acc_r <= '0;
                if (en) begin
                    collision_mask <= hit_acc_r;
                    hit_count      <= hit_sum_s[8] ? 8'hFF : hit_sum_s[7:0];
                    timer_r        <= spawn_due_s ? '0 : timer_r + TW'(1);
                    active_mask    <= act_nx_s;
                    for (int i = 0; i < N_OBST; i++) begin
                        x_r[i]  <= x_nx_s[i];
                        y_r[i]  <= y_nx_s[i];
                        dx_r[i] <= dx_nx_s[i];
                        dy_r[i] <= dy_nx_s[i];
                    end
                end else begin
                    collision_mask <= '0;
                end
            end else if (en) begin
                hit_acc_r <= hit_acc_r | (ship_drawing ? slot_hit_r : '0);
            end else begin
                hit_acc_r <= '0;
            end
        end
    end

endmodule

`default_nettype wire
